pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Upstream neighbour of the fetch stage. Owns the program counter and issues word
//  requests to the icache with a req/ack handshake, at most one outstanding.
//  Buffers returned words in a small prefetch queue and presents them, with PC and
//  error tag, to the fetch stage. Handles branch redirects and icache errors.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] ignored (forced 0)
//  DEPTH     2              prefetch queue entries; power of two, >= 2
// PORTS
//  clk             in   1   single clock; all flops rising-edge
//  rst             in   1   reset, asynchronous, active-high
//  stall           in   1   fetch stage cannot accept; head entry held
//  redirect_valid  in   1   branch/jump redirect, one-cycle pulse
//  redirect_pc     in   32  redirect target; bits [1:0] forced 0
//  icache_req      out  1   request valid; held until icache_ack
//  icache_addr     out  32  word address; stable while icache_req && !icache_ack
//  icache_ack      in   1   request accepted, data/error valid in this cycle
//  icache_rdata    in   32  instruction word, valid with icache_ack
//  icache_error    in   1   access fault, valid with icache_ack
//  fetch_valid     out  1   head of queue valid
//  fetch_instr     out  32  head instruction word
//  fetch_pc        out  32  PC of head instruction
//  fetch_err       out  1   head entry carries an icache error
// BEHAVIOUR
//  Reset (async, active-high): pc=RESET_PC; queue empty; state=IDLE. All outputs 0
//   except icache_addr=RESET_PC.
//  FSM states: IDLE, REQ, DISCARD, HALT.
//   IDLE->REQ when (count+0)<DEPTH; first req is in the 1st cycle after rst deasserts.
//   REQ: icache_req=1, icache_addr=pc. On ack: push {pc,rdata,error}; pc+=4, wrapping
//    0xFFFF_FFFC->0. If error: HALT. Else stay in REQ if the queue has room after
//    push/pop this cycle, otherwise IDLE.
//   DISCARD: entered on redirect while REQ un-acked. Keep req high at the old addr
//    until ack, drop the data, then go to REQ at the redirected pc.
//   HALT: no requests until redirect_valid.
//  Redirect (any state): queue flushed same cycle (fetch_valid=0 next cycle);
//   pc<=redirect_pc. Ack in the same cycle: data dropped, next req to redirect_pc,
//   no DISCARD. Redirect overrides stall and error.
//  Queue: pop when fetch_valid && !stall. Push and pop in one cycle when full is
//   legal. Never push when full; issue throttling guarantees this, and the bench
//   asserts it.
//  Latency: ack in cycle N -> fetch_valid/fetch_instr in cycle N+1 (registered).
//   Back-to-back acks give 1 instr/cycle sustained.
//  Stall: head entry and fetch_* outputs held stable. Requests continue until full.
//  icache_addr[1:0] is always 0. A zero instruction word is queued like any other;
//   fetch-stage validity is decided downstream.
// STRUCTURE
//  fetch_pkg: typedef enum logic [1:0] pcgen_state_e {IDLE,REQ,DISCARD,HALT};
//   typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic err;} fetch_entry_t;
//   localparam PC_STEP = 32'd4.
//  Sub-module fetch_queue: sync FIFO of fetch_entry_t, DEPTH param, with push, pop,
//   flush, full, empty and count outputs. Same clk/rst.
//  pc_gen holds the FSM, the pc register and issue throttling; about 200 lines total.
// TESTING
//  1 Reset, ack every cycle with rdata=addr^0xA5A5A5A5 -> addrs 0,4,8,...; fetch_pc
//    and fetch_instr match; 1 instr/cycle after the first.
//  2 stall held 5 cycles -> queue fills to DEPTH, then icache_req=0; fetch_* stable.
//    Release -> drains in order, no loss or duplicate.
//  3 Redirect to 0x100 while req at 0x8 is un-acked (ack 3 cycles later) -> addr held
//    at 0x8 until ack; data dropped; next req addr=0x100; fetch_valid=0 meanwhile.
//  4 Redirect to 0x200 in the same cycle as ack of 0xC -> 0xC never appears; next
//    fetch_pc=0x200.
//  5 icache_error on ack at 0x10 -> fetch_err=1, fetch_pc=0x10; no further req until
//    redirect to 0x40; then requests resume at 0x40.
//  6 Redirect to 0xFFFF_FFFC -> next addrs 0xFFFF_FFFC then 0x0. Assert rst mid-REQ
//    -> all outputs 0 at once (icache_addr=RESET_PC).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the PC generator and its prefetch queue.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} pcgen_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries; push-to-head visibility is one cycle.
// Flush empties the queue and wins over a same-cycle push or pop.
module fetch_queue import fetch_pkg::*; #(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is only observed while non-empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_q] <= push_entry;
    end

    assign head  = mem[rd_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
endmodule

// File: rtl/pc_gen.sv
// PC generator: one outstanding icache request, returned words reach fetch_* one cycle after ack.
// Stall holds the head; requests continue until the prefetch queue would be full.
module pc_gen import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ack,
    input  logic [31:0] icache_rdata,
    input  logic        icache_error,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        fetch_err
);
    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C    = (CW+1)'(DEPTH);
    localparam logic [31:0] RESET_PC_W = RESET_PC & ~32'h3;

    pcgen_state_e  state_q;
    logic [31:0]   pc_q, addr_q;
    logic          req_q;
    logic [31:0]   redir_pc, pc_next;
    logic          q_push, q_pop, q_full, q_empty, room_after;
    logic [CW-1:0] q_count;
    logic [CW:0]   cnt_after;
    fetch_entry_t  q_head, push_entry;

    assign redir_pc = redirect_pc & ~32'h3;
    assign pc_next  = pc_q + PC_STEP;

    // In REQ, pc_q always equals the address of the outstanding request.
    assign q_push     = icache_ack && (state_q == REQ) && !redirect_valid;
    assign q_pop      = !q_empty && !stall;
    assign push_entry = '{pc: pc_q, instr: icache_rdata, err: icache_error};
    assign cnt_after  = {1'b0, q_count} + (CW+1)'(q_push) - (CW+1)'(q_pop);
    assign room_after = (cnt_after < DEPTH_C);

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_entry (push_entry),
        .pop        (q_pop),
        .flush      (redirect_valid),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC_W;
            addr_q  <= RESET_PC_W;
            req_q   <= 1'b0;
        end else if (redirect_valid) begin
            pc_q <= redir_pc;
            if (req_q && !icache_ack) begin
                // The icache still owns the old request; keep it up and drop its data.
                state_q <= DISCARD;
            end else begin
                state_q <= REQ;
                req_q   <= 1'b1;
                addr_q  <= redir_pc;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!q_full) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                REQ: begin
                    if (icache_ack) begin
                        pc_q   <= pc_next;
                        addr_q <= pc_next;
                        if (icache_error) begin
                            state_q <= HALT;
                            req_q   <= 1'b0;
                        end else if (!room_after) begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (icache_ack) begin
                        state_q <= REQ;
                        addr_q  <= pc_q;
                    end
                end
                HALT: ;
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign icache_req  = req_q;
    assign icache_addr = addr_q;
    assign fetch_valid = !q_empty;
    assign fetch_instr = q_empty ? 32'h0 : q_head.instr;
    assign fetch_pc    = q_empty ? 32'h0 : q_head.pc;
    assign fetch_err   = !q_empty && q_head.err;
endmodule
